// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state codes and default timing limits for the RAM port controller
package ram_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_FILL  = 2'd2,
      S_SCAN  = 2'd3
   } state_t;

   localparam int DEF_DB_CNT   = 1_000_000;
   localparam int DEF_STEP_CNT = 50_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser and debouncer
// Emits a one-cycle press pulse on each accepted rising level.
module btn_debounce
   import ram_ctrl_pkg::*;
#(
   parameter int DB_CNT = DEF_DB_CNT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      stable_d = stable_q;
      press_d  = 1'b0;
      cnt_d    = cnt_q + 1'b1;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // Level held long enough: accept it and pulse only on a rising level.
         stable_d = sync2_q;
         press_d  = sync2_q;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - button/switch front end driving single-port RAM strobes
// Single write, full-array fill and timed read-back scan.
module ram_port_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int AW       = 4,
   parameter int DW       = 8,
   parameter int DB_CNT   = DEF_DB_CNT,
   parameter int STEP_CNT = DEF_STEP_CNT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_wr,
   input  logic          btn_fill,
   input  logic          btn_scan,
   input  logic [AW-1:0] sw_addr,
   input  logic [DW-1:0] sw_data,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          busy,
   output logic [1:0]    mode
);

   localparam int SW = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CNT - 1);
   localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

   logic wr_p, fill_p, scan_p;

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_wr   (.clk(clk), .rst(rst), .btn_raw(btn_wr),   .press(wr_p));
   btn_debounce #(.DB_CNT(DB_CNT)) u_db_fill (.clk(clk), .rst(rst), .btn_raw(btn_fill), .press(fill_p));
   btn_debounce #(.DB_CNT(DB_CNT)) u_db_scan (.clk(clk), .rst(rst), .btn_raw(btn_scan), .press(scan_p));

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic [SW-1:0] step_q, step_d;

   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      step_d  = step_q;
      case (state_q)
         S_IDLE: begin
            addr_d = sw_addr;
            din_d  = sw_data;
            if (wr_p) begin
               state_d = S_WRITE;
               we_d    = 1'b1;
            end else if (fill_p) begin
               state_d = S_FILL;
               we_d    = 1'b1;
               addr_d  = '0;
            end else if (scan_p) begin
               state_d = S_SCAN;
               addr_d  = '0;
               step_d  = '0;
            end
         end
         S_WRITE: begin
            state_d = S_IDLE;
            addr_d  = sw_addr;
            din_d   = sw_data;
         end
         S_FILL: begin
            // The last address is written on this cycle; stop rather than wrap.
            if (addr_q == ADDR_LAST) begin
               state_d = S_IDLE;
               addr_d  = sw_addr;
               din_d   = sw_data;
            end else begin
               we_d   = 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         S_SCAN: begin
            if (scan_p) begin
               state_d = S_IDLE;
               addr_d  = sw_addr;
               din_d   = sw_data;
               step_d  = '0;
            end else if (step_q == STEP_LAST) begin
               step_d = '0;
               addr_d = addr_q + 1'b1;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_WRITE) || (state_d == S_FILL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         step_q  <= step_d;
      end
   end

   assign ram_we   = we_q;
   assign ram_addr = addr_q;
   assign ram_din  = din_q;
   assign busy     = busy_q;
   assign mode     = state_q;

endmodule
